// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared state encoding, constants and helpers for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHK    = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    // States in which the loader presents byte_ready.
    function automatic logic is_rx_state(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

    function automatic logic len_ok(input logic [COUNT_W-1:0] len, input int max_words);
        return (len != '0) && (int'(len) <= max_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream handshake and imem write bus of the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) ();
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_wr_en;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wr_data;

    // Stream source / memory sink side
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_wr_en, mem_addr, mem_wr_data
    );

    // Loader side
    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_wr_en, mem_addr, mem_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_byte_packer
// Description : Packs accepted bytes MSB-first into 32-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    // Completed word is presented in the same cycle as its 4th byte.
    assign o_word       = {r_shift, i_data};
    assign o_word_valid = i_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_valid) begin
            r_shift <= {r_shift[15:0], i_data};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Length-prefixed byte-stream loader for imem; holds the CPU in
//               reset until the image is written. Optional trailing XOR
//               checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    imem_loader_if.slave bus,
    output logic         o_cpu_rstn,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [COUNT_W-1:0]  r_count;
    logic [COUNT_W-1:0]  w_len;
    logic [AWIDTH:0]     r_word_idx;
    logic [AWIDTH:0]     w_idx_inc;
    logic [AWIDTH-1:0]   r_mem_addr;
    logic [DWIDTH-1:0]   r_mem_wr_data;
    logic                w_byte_ready;
    logic                w_hs;
    logic                w_start_acc;
    logic                w_last_word;
    logic                w_word_valid;
    logic [31:0]         w_word;

    assign w_byte_ready = is_rx_state(r_state);
    assign w_hs         = bus.byte_valid && w_byte_ready;
    assign w_start_acc  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_len        = {r_count[COUNT_W-1:8], bus.byte_data};
    assign w_idx_inc    = r_word_idx + (AWIDTH+1)'(1);
    // Index is one bit wider than the address so a count of 2**AWIDTH compares exactly.
    assign w_last_word  = (COUNT_W'(w_idx_inc) == r_count);

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_acc),
        .i_valid      (w_hs && (r_state == ST_DATA)),
        .i_data       (bus.byte_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_csum <= '0;
        end else if (w_hs && (r_state == ST_DATA)) begin
            r_csum <= r_csum ^ bus.byte_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (i_start) w_state_nxt = ST_LEN_HI;
            ST_LEN_HI: if (w_hs) w_state_nxt = ST_LEN_LO;
            ST_LEN_LO: if (w_hs) w_state_nxt = len_ok(w_len, MAX_WORDS) ? ST_DATA : ST_ERR;
            ST_DATA:   if (w_word_valid) w_state_nxt = ST_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_WRITE:  w_state_nxt = w_last_word ? ST_CHK : ST_DATA;
            ST_CHK:    if (w_hs) w_state_nxt = (bus.byte_data == r_csum) ? ST_DONE : ST_ERR;
`else
            ST_WRITE:  w_state_nxt = w_last_word ? ST_DONE : ST_DATA;
            ST_CHK:    w_state_nxt = ST_ERR;
`endif
            ST_DONE:   if (i_start) w_state_nxt = ST_LEN_HI;
            ST_ERR:    if (i_start) w_state_nxt = ST_LEN_HI;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.byte_ready = w_byte_ready;
        bus.mem_wr_en  = (r_state == ST_WRITE);
        o_busy         = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) || (r_state == ST_DATA)
                      || (r_state == ST_WRITE)  || (r_state == ST_CHK);
        o_done         = (r_state == ST_DONE);
        o_err          = (r_state == ST_ERR);
        o_cpu_rstn     = (r_state == ST_DONE);
    end

    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wr_data = r_mem_wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_word_idx    <= '0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
        end else begin
            if (w_start_acc) begin
                r_count    <= '0;
                r_word_idx <= '0;
            end
            if ((r_state == ST_LEN_HI) && w_hs) begin
                r_count[COUNT_W-1:8] <= bus.byte_data;
            end
            if ((r_state == ST_LEN_LO) && w_hs) begin
                r_count[7:0] <= bus.byte_data;
            end
            // Address and data are captured one cycle ahead so they hold outside WRITE.
            if (w_word_valid) begin
                r_mem_addr    <= r_word_idx[AWIDTH-1:0];
                r_mem_wr_data <= DWIDTH'(w_word);
            end
            if (r_state == ST_WRITE) begin
                r_word_idx <= w_idx_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader with a stream-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cpu_rstn, busy, done, err;

    imem_loader_if #(.AWIDTH(10), .DWIDTH(32)) bus ();

    imem_loader #(.AWIDTH(10), .DWIDTH(32), .MAX_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .bus        (bus),
        .o_cpu_rstn (cpu_rstn),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stream-level model: phase 0 idle, 1 loading, 2 done, 3 error.
    bit          m_valid = 0;
    int          m_phase;
    int          m_nlen;
    logic [15:0] m_len;
    logic [7:0]  m_data[$];
    logic [7:0]  m_xor;
    bit          m_chk_wait;
    bit          m_wr_pending;
    logic [9:0]  m_exp_addr, m_last_addr;
    logic [31:0] m_exp_data, m_last_data;
    bit          exp_ready, hs;
    logic [5:0]  exp_st, act_st;
    int          nw;

    logic [31:0] shadow[1024];
    int          n_wr = 0, n_wr0 = 0;
    logic [9:0]  last_wr_addr = '0;

    always @(negedge clk) begin
        if (m_valid) begin
            if (m_wr_pending) begin
                m_last_addr = m_exp_addr;
                m_last_data = m_exp_data;
            end
            exp_ready = (m_phase == 1) && !m_wr_pending;
            exp_st = {m_wr_pending, exp_ready, m_phase == 1, m_phase == 2, m_phase == 3, m_phase == 2};
            act_st = {bus.mem_wr_en, bus.byte_ready, busy, done, err, cpu_rstn};
            chk("status{wr,rdy,busy,done,err,rstn}", 32'(act_st), 32'(exp_st));
            chk("mem_addr", 32'(bus.mem_addr), 32'(m_last_addr));
            chk("mem_wr_data", bus.mem_wr_data, m_last_data);
            if (bus.mem_wr_en === 1'b1) begin
                shadow[bus.mem_addr] = bus.mem_wr_data;
                n_wr++;
                if (bus.mem_addr == 10'd0) n_wr0++;
                last_wr_addr = bus.mem_addr;
            end
        end
        exp_ready = (m_phase == 1) && !m_wr_pending;
        hs = bus.byte_valid && exp_ready;
        if (rst) begin
            m_valid = 1; m_phase = 0; m_wr_pending = 0; m_chk_wait = 0;
            m_last_addr = '0; m_last_data = '0;
        end else if (start && m_phase != 1) begin
            m_phase = 1; m_nlen = 0; m_data.delete(); m_xor = '0; m_chk_wait = 0;
        end else if (m_wr_pending) begin
            m_wr_pending = 0;
            if (m_data.size() / 4 == int'(m_len)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                m_chk_wait = 1;
`else
                m_phase = 2;
`endif
            end
        end else if (hs) begin
            if (m_nlen < 2) begin
                m_len = {m_len[7:0], bus.byte_data};
                m_nlen++;
                if (m_nlen == 2 && (m_len == 16'd0 || m_len > 16'd1024)) m_phase = 3;
            end else if (m_chk_wait) begin
                m_chk_wait = 0;
                m_phase = (bus.byte_data == m_xor) ? 2 : 3;
            end else begin
                m_data.push_back(bus.byte_data);
                m_xor ^= bus.byte_data;
                nw = m_data.size();
                if (nw % 4 == 0) begin
                    m_wr_pending = 1;
                    m_exp_addr = 10'(nw / 4 - 1);
                    m_exp_data = {m_data[nw-4], m_data[nw-3], m_data[nw-2], m_data[nw-1]};
                end
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget = 100;
        if (gaps) repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && budget > 0) begin @(posedge clk); #1; budget--; end
        if (budget == 0) begin
            n_chk++; n_fail++;
            $display("FAIL hs_timeout: byte_ready stayed %b, required 1", bus.byte_ready);
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] q[$], input bit gaps);
        foreach (q[i]) send_byte(q[i], gaps);
    endtask

    task automatic send_csum(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(b, 1'b0);
`else
        if (b === 8'hxx) $display("unused checksum byte");
`endif
    endtask

    task automatic wait_status(input int budget);
        while (!(done || err) && budget > 0) begin @(posedge clk); #1; budget--; end
        if (budget == 0) begin
            n_chk++; n_fail++;
            $display("FAIL status_timeout: done=%b err=%b, required one set", done, err);
        end
    endtask

    logic [7:0] basic[$] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] b8, fx;

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outputs", 32'({busy, done, err, cpu_rstn, bus.byte_ready, bus.mem_wr_en}), 32'd0);
        chk("reset_addr_data", 32'(bus.mem_addr) | bus.mem_wr_data, 32'd0);

        // Basic load
        do_start();
        send_list(basic, 1'b0);
        send_csum(8'h2D);
        wait_status(50);
        chk("basic_done", 32'({done, cpu_rstn, err}), 32'b110);
        chk("basic_word0", shadow[0], 32'h2008_0005);
        chk("basic_word1", shadow[1], 32'h0000_0000);
        chk("basic_nwrites", 32'(n_wr), 32'd2);

        // Back-pressure
        shadow[0] = '0; shadow[1] = 32'hFFFF_FFFF; n_wr = 0;
        do_start();
        send_list(basic, 1'b1);
        send_csum(8'h2D);
        wait_status(50);
        chk("bp_word0", shadow[0], 32'h2008_0005);
        chk("bp_word1", shadow[1], 32'h0000_0000);
        chk("bp_nwrites", 32'(n_wr), 32'd2);

        // Bad lengths: 0 and 1025
        n_wr = 0;
        do_start();
        send_list('{8'h00, 8'h00}, 1'b0);
        wait_status(10);
        chk("len0_err", 32'({err, done, cpu_rstn}), 32'b100);
        do_start();
        send_list('{8'h04, 8'h01}, 1'b0);
        wait_status(10);
        chk("len1025_err", 32'({err, done, cpu_rstn}), 32'b100);
        chk("badlen_nwrites", 32'(n_wr), 32'd0);

        // Full image of 1024 words
        n_wr = 0; n_wr0 = 0; fx = '0;
        do_start();
        send_list('{8'h04, 8'h00}, 1'b0);
        for (int i = 0; i < 4096; i++) begin
            b8 = 8'((i * 7) ^ (i >> 3));
            fx ^= b8;
            send_byte(b8, 1'b0);
        end
        send_csum(fx);
        wait_status(50);
        chk("full_done", 32'({done, err}), 32'b10);
        chk("full_last_addr", 32'(last_wr_addr), 32'd1023);
        chk("full_nwrites", 32'(n_wr), 32'd1024);
        chk("full_addr0_once", 32'(n_wr0), 32'd1);

        // Reset mid-load after 6 data bytes
        do_start();
        send_list('{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_outputs", 32'({busy, done, err, cpu_rstn, bus.byte_ready, bus.mem_wr_en}), 32'd0);
        chk("midrst_addr_data", 32'(bus.mem_addr) | bus.mem_wr_data, 32'd0);
        do_start();
        send_list('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0);
        send_csum(8'h22);
        wait_status(50);
        chk("reload_word0", shadow[0], 32'hDEAD_BEEF);
        chk("reload_done", 32'({done, cpu_rstn}), 32'b11);

        // rst and start in the same cycle: rst wins
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_beats_start", 32'({busy, done, cpu_rstn}), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_start();
        send_list(basic, 1'b0);
        send_csum(8'h00);
        wait_status(50);
        chk("csum_bad_err", 32'({err, done, cpu_rstn}), 32'b100);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
